// File: rtl/piso_serializer_pkg.sv
// Shared FSM constants: serializer state encoding alongside the sequence-detector
// state and pattern constants that consume the serial stream.
package piso_serializer_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  // Detector states track how many leading pattern bits have been matched.
  typedef enum logic [1:0] {
    SD_S0 = 2'd0,
    SD_S1 = 2'd1,
    SD_S2 = 2'd2,
    SD_S3 = 2'd3
  } sd_state_e;

  localparam int         SD_PATTERN_LEN = 4;
  localparam logic [3:0] SD_PATTERN     = 4'b0110;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load handshake, gapless
// back-to-back streaming, synchronous flush and async active-low reset.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             par_valid,
  output logic             par_ready,
  input  logic             flush,
  output logic             data_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             data_out_q, data_out_d;
  logic             last_bit_q, last_bit_d;
  logic             load;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    // Gating with rst keeps ready low while reset is held.
    par_ready = rst && ((state_q == PISO_IDLE) || last_bit_q);
    load      = par_valid && par_ready && !flush;

    if (flush) begin
      state_d = PISO_IDLE;
      count_d = '0;
      shreg_d = '0;
    end else if (load) begin
      state_d = PISO_SHIFT;
      count_d = '0;
      shreg_d = par_in;
    end else if (state_q == PISO_SHIFT) begin
      if (last_bit_q) begin
        state_d = PISO_IDLE;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      end
    end

    last_bit_d = (state_d == PISO_SHIFT) && (count_d == LAST_CNT);
    data_out_d = (state_d == PISO_SHIFT) ? head_bit(shreg_d) : IDLE_LEVEL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PISO_IDLE;
      count_q    <= '0;
      shreg_q    <= '0;
      data_out_q <= IDLE_LEVEL;
      last_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      last_bit_q <= last_bit_d;
    end
  end

  assign busy      = (state_q == PISO_SHIFT);
  assign bit_valid = busy;
  assign data_out  = data_out_q;
  assign last_bit  = last_bit_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed serial bits, monitors pop and
// compare whenever bit_valid is high; directed checks cover ready/flush/reset.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  typedef struct {
    logic b;
    logic last;
    logic chk;
    logic pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] par_in_a, par_in_b;
  logic       par_valid_a, par_valid_b;
  logic       flush_a, flush_b;
  logic       par_ready_a, par_ready_b;
  logic       data_out_a, data_out_b;
  logic       bit_valid_a, bit_valid_b;
  logic       last_bit_a, last_bit_b;
  logic       busy_a, busy_b;

  int   tests = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [3:0] hist = 4'b0;
  int   hcnt = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .par_in(par_in_a), .par_valid(par_valid_a),
    .par_ready(par_ready_a), .flush(flush_a), .data_out(data_out_a),
    .bit_valid(bit_valid_a), .last_bit(last_bit_a), .busy(busy_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .par_in(par_in_b), .par_valid(par_valid_b),
    .par_ready(par_ready_b), .flush(flush_b), .data_out(data_out_b),
    .bit_valid(bit_valid_b), .last_bit(last_bit_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // stream is written in wire order, leftmost bit first.
  task automatic push_stream(input logic [15:0] stream, input int n, input logic [15:0] pulses,
                             input bit chk, input bit to_b);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b     = stream[n-1-i];
      e.last  = ((i % 8) == 7);
      e.chk   = chk;
      e.pulse = pulses[n-1-i];
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic send_a(input logic [7:0] w);
    @(posedge clk); #1;
    par_in_a = w; par_valid_a = 1'b1;
    @(posedge clk); #1;
    par_valid_a = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, (qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b), 1);
  endtask

  always @(negedge clk) begin
    if (bit_valid_a) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_bit: got data_out=%0b with no bit pending, required no bit", data_out_a);
      end else begin
        ea = qa.pop_front();
        check("a_data_out", data_out_a, ea.b);
        check("a_last_bit", last_bit_a, ea.last);
        if (ea.chk) begin
          hist = {hist[2:0], data_out_a};
          if (hcnt < SD_PATTERN_LEN) hcnt++;
          check("det_pulse", (hcnt >= SD_PATTERN_LEN) && (hist == SD_PATTERN), ea.pulse);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bit_valid_b) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_bit: got data_out=%0b with no bit pending, required no bit", data_out_b);
      end else begin
        eb = qb.pop_front();
        check("b_data_out", data_out_b, eb.b);
        check("b_last_bit", last_bit_b, eb.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    par_in_a = '0; par_valid_a = 1'b0; flush_a = 1'b0;
    par_in_b = '0; par_valid_b = 1'b0; flush_b = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_bit_valid", bit_valid_a, 0);
    check("rst_busy",      busy_a,      0);
    check("rst_par_ready", par_ready_a, 0);
    check("rst_data_out",  data_out_a,  0);
    check("rst_last_bit",  last_bit_a,  0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_after_rst", par_ready_a, 1);

    // Single word 0110_0110, par_in wiggled while not ready
    push_stream(16'b0110_0110, 8, 16'h0, 1'b0, 1'b0);
    send_a(8'b0110_0110);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("w1_bit_valid_c%0d", k), bit_valid_a, 1);
      check($sformatf("w1_ready_c%0d", k), par_ready_a, (k == 8));
      if (k == 2) begin par_in_a = 8'hFF; par_valid_a = 1'b1; end
      if (k == 6) begin par_valid_a = 1'b0; end
    end
    @(negedge clk);
    check("w1_idle_valid", bit_valid_a, 0);
    check("w1_idle_data",  data_out_a,  0);
    check("w1_idle_busy",  busy_a,      0);

    // Back-to-back B6 then 0F
    push_stream(16'hB60F, 16, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    par_in_a = 8'hB6; par_valid_a = 1'b1;
    @(posedge clk); #1;
    par_in_a = 8'h0F;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("b2b_valid_c%0d", k), bit_valid_a, 1);
      check($sformatf("b2b_ready_c%0d", k), par_ready_a, (k == 8 || k == 16));
      if (k == 8) begin
        @(posedge clk); #1;
        par_valid_a = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle_valid", bit_valid_a, 0);

    // Flush during bit index 3 of FF
    push_stream(16'b1111, 4, 16'h0, 1'b0, 1'b0);
    send_a(8'hFF);
    repeat (3) @(posedge clk);
    #1 flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    check("flush_valid", bit_valid_a, 0);
    check("flush_busy",  busy_a,      0);
    check("flush_ready", par_ready_a, 1);
    check("flush_data",  data_out_a,  0);
    flush_a = 1'b1; par_in_a = 8'hAA; par_valid_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0; par_valid_a = 1'b0;
    check("flush_prio_busy", busy_a, 0);
    @(negedge clk);
    check("flush_prio_valid", bit_valid_a, 0);

    // Async reset mid-word of A5: only bits 1,0,1 are sampled before it hits
    push_stream(16'b101, 3, 16'h0, 1'b0, 1'b0);
    send_a(8'hA5);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_valid", bit_valid_a, 0);
    check("arst_busy",  busy_a,      0);
    check("arst_ready", par_ready_a, 0);
    check("arst_data",  data_out_a,  0);
    check("arst_last",  last_bit_a,  0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("arst_release_ready", par_ready_a, 1);
    push_stream(16'b0011_1100, 8, 16'h0, 1'b0, 1'b0);
    send_a(8'h3C);
    drain("drain_after_arst");

    // LSB-first instance with 8'h01
    push_stream(16'b1000_0000, 8, 16'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    par_in_b = 8'h01; par_valid_b = 1'b1;
    @(posedge clk); #1;
    par_valid_b = 1'b0;
    drain("drain_lsb");

    // End-to-end: 0110_1100 then 1011_0000; pattern 0110 completes at stream bits 3, 6, 12
    push_stream(16'b0110_1100_1011_0000, 16, 16'h1208, 1'b1, 1'b0);
    @(posedge clk); #1;
    par_in_a = 8'b0110_1100; par_valid_a = 1'b1;
    @(posedge clk); #1;
    par_in_a = 8'b1011_0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!par_ready_a && n < 20);
    check("e2e_second_ready", par_ready_a, 1);
    @(posedge clk); #1;
    par_valid_a = 1'b0;
    drain("drain_e2e");

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 out first; 0 shifts bit 0 out first.
REQ-003 Parameter IDLE_LEVEL, default 0: level driven on data_out when no bit is valid.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous assertion, active-low.
REQ-006 par_in  input  WIDTH  parallel word to serialize.
REQ-007 par_valid  input  1  par_in holds a word to transfer.
REQ-008 par_ready  output  1  block accepts a word this cycle.
REQ-009 flush  input  1  synchronous abort of the word in flight.
REQ-010 data_out  output  1  serial bit stream; feeds the sequence detector's data_in.
REQ-011 bit_valid  output  1  data_out carries a payload bit this cycle.
REQ-012 last_bit  output  1  current bit is the final bit of its word.
REQ-013 busy  output  1  a word is in flight.

Function
REQ-014 The FSM SHALL have exactly two states:
- IDLE: no word.
- SHIFT: WIDTH bits in progress.
REQ-015 A transfer SHALL occur on a rising edge where par_valid and par_ready are both 1, and flush is 0.
REQ-016 par_ready SHALL be combinational: 1 in IDLE, or in SHIFT on the last_bit cycle (gapless streaming); otherwise 0.
REQ-017 Transfer timing: par_in SHALL be captured into the shift register at the transfer edge. The first bit SHALL appear on data_out, with bit_valid=1, in the following cycle (latency 1).
REQ-018 Each bit SHALL be held for exactly one clock. Bit count SHALL run 0..WIDTH-1 in a $clog2(WIDTH)-bit counter. last_bit=1 when count==WIDTH-1.
REQ-019 End of word with a transfer on the last_bit edge: the new word SHALL load and SHIFT continues with count=0. There SHALL be no idle cycle between words.
REQ-020 End of word without a transfer: the FSM SHALL return to IDLE. bit_valid SHALL be 0 and data_out SHALL equal IDLE_LEVEL from the next cycle.
REQ-021 flush=1 in any state SHALL force IDLE at the next edge and discard the word. flush SHALL take priority over a simultaneous par_valid, and no transfer occurs.
REQ-022 busy SHALL equal (state==SHIFT). bit_valid SHALL equal busy.
REQ-023 par_in changes while par_ready=0 SHALL have no effect.

Reset
REQ-024 While rst=0, the block SHALL hold these values:
- state IDLE, count 0, shift register 0.
- data_out=IDLE_LEVEL.
- bit_valid=0, last_bit=0, busy=0.
- par_ready=0.
REQ-025 Reset SHALL take effect asynchronously, including mid-word. The partial word is lost.
REQ-026 par_ready SHALL first be 1 in the first cycle after rst deasserts.

Structure
REQ-027 The state encoding (IDLE, SHIFT) SHALL live in the shared FSM package, next to the sequence-detector state constants.
REQ-028 The block SHALL be one flat module with no sub-modules. Counter and shift register SHALL be in one sequential process, and next-state/par_ready logic in one combinational process.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Load 8'b0110_0110, MSB_FIRST=1, par_valid held high for 1 cycle -> data_out 0,1,1,0,0,1,1,0 on 8 consecutive cycles with bit_valid=1. last_bit=1 on the 8th bit only. Then IDLE with data_out=0.
- Back-to-back words 8'hB6 then 8'h0F, par_valid held high -> 16 contiguous bit_valid cycles. par_ready=1 on cycles 8 and 16 only.
- flush asserted during bit index 3 of 8'hFF -> bit_valid=0 and busy=0 the next cycle. par_ready=1. Remaining 4 bits never appear.
- rst pulled to 0 asynchronously mid-word (between clock edges) -> bit_valid, busy and par_ready go 0 immediately. The next word after release serializes from bit 0.
- MSB_FIRST=0 with word 8'h01 -> data_out 1,0,0,0,0,0,0,0.
- End-to-end: serializer drives the Mealy detector with words 8'b0110_1100 then 8'b1011_0000 -> detector output pulses match a reference model of the combined 16-bit stream, including overlapping matches.
